// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// controller states, FUNC3 access codes and address-field widths.
package data_cache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      UPDATE    = 2'd3
   } state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned OFFSET_W    = 4;
   localparam int unsigned DEF_INDEX_W = 3;
   localparam int unsigned DEF_TAG_W   = ADDR_W - OFFSET_W - DEF_INDEX_W;
   localparam int unsigned BLOCK_W     = 128;
   localparam int unsigned MEM_ADDR_W  = ADDR_W - OFFSET_W;

endpackage

// File: rtl/data_cache_byte_lane.sv
// Combinational load extraction/extension and store byte-merge for one
// 16-byte cache line; sub-word lanes are aligned by truncating the offset.
module cache_byte_lane
   import data_cache_pkg::*;
(
   input  logic [BLOCK_W-1:0]  block_i,
   input  logic [OFFSET_W-1:0] offset_i,
   input  logic [2:0]          func3_i,
   input  logic [31:0]         wdata_i,
   output logic [31:0]         load_o,
   output logic [BLOCK_W-1:0]  store_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] word_sel;

   always_comb begin
      byte_sel = block_i[{offset_i, 3'b000} +: 8];
      half_sel = block_i[{offset_i[3:1], 4'b0000} +: 16];
      word_sel = block_i[{offset_i[3:2], 5'b00000} +: 32];

      case (func3_i)
         F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
         F3_W:    load_o = word_sel;
         F3_BU:   load_o = {24'h000000, byte_sel};
         F3_HU:   load_o = {16'h0000, half_sel};
         default: load_o = '0;
      endcase

      store_o = block_i;
      case (func3_i)
         F3_B:    store_o[{offset_i, 3'b000} +: 8]        = wdata_i[7:0];
         F3_H:    store_o[{offset_i[3:1], 4'b0000} +: 16] = wdata_i[15:0];
         F3_W:    store_o[{offset_i[3:2], 5'b00000} +: 32] = wdata_i;
         default: store_o = block_i;
      endcase
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with zero-stall hits
// and a four-state miss controller talking to a 128-bit block memory.
module data_cache
   import data_cache_pkg::*;
#(
   parameter int unsigned LINES       = 8,
   parameter int unsigned BLOCK_BYTES = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [ADDR_W-1:0]     ADDRESS,
   input  logic [31:0]           WRITE_DATA,
   input  logic [2:0]            FUNC3,
   output logic [31:0]           READ_DATA,
   output logic                  BUSYWAIT,
   output logic                  MEM_READ,
   output logic                  MEM_WRITE,
   output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
   output logic [BLOCK_W-1:0]    MEM_WRITE_DATA,
   input  logic [BLOCK_W-1:0]    MEM_READ_DATA,
   input  logic                  MEM_BUSYWAIT
);

   localparam int unsigned INDEX_W = $clog2(LINES);
   localparam int unsigned TAG_W   = ADDR_W - OFFSET_W - INDEX_W;
   localparam int unsigned LINE_W  = BLOCK_BYTES * 8;

   logic [TAG_W-1:0]    tag;
   logic [INDEX_W-1:0]  index;
   logic [OFFSET_W-1:0] offset;

   logic [LINE_W-1:0] data_q [LINES];
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINES-1:0]  valid_q, valid_d;
   logic [LINES-1:0]  dirty_q, dirty_d;

   state_e            state_q, state_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [LINE_W-1:0] fill_q, fill_d;

   logic              hit;
   logic [LINE_W-1:0] line;
   logic [31:0]       load_data;
   logic [LINE_W-1:0] store_block;
   logic              arr_we;
   logic [LINE_W-1:0] arr_wdata;

   assign tag    = ADDRESS[ADDR_W-1 -: TAG_W];
   assign index  = ADDRESS[OFFSET_W +: INDEX_W];
   assign offset = ADDRESS[OFFSET_W-1:0];
   assign line   = data_q[index];
   assign hit    = valid_q[index] && (tag_q[index] == tag);

   cache_byte_lane u_lane (
      .block_i  (line),
      .offset_i (offset),
      .func3_i  (FUNC3),
      .wdata_i  (WRITE_DATA),
      .load_o   (load_data),
      .store_o  (store_block)
   );

   always_comb begin
      state_d     = state_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      fill_d      = fill_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      arr_we      = 1'b0;
      arr_wdata   = line;

      case (state_q)
         IDLE: begin
            // Store takes priority over load when both are requested.
            if (WRITE && hit) begin
               arr_we         = 1'b1;
               arr_wdata      = store_block;
               dirty_d[index] = 1'b1;
            end else if ((READ || WRITE) && !hit) begin
               if (dirty_q[index]) begin
                  state_d     = WRITEBACK;
                  mem_write_d = 1'b1;
               end else begin
                  state_d    = FETCH;
                  mem_read_d = 1'b1;
               end
            end
         end
         WRITEBACK: begin
            if (!MEM_BUSYWAIT) begin
               state_d     = FETCH;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
            end
         end
         FETCH: begin
            if (!MEM_BUSYWAIT) begin
               state_d    = UPDATE;
               mem_read_d = 1'b0;
               fill_d     = MEM_READ_DATA;
            end
         end
         UPDATE: begin
            arr_we         = 1'b1;
            arr_wdata      = fill_q;
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         fill_q      <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         fill_q      <= fill_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (arr_we) begin
         data_q[index] <= arr_wdata;
         tag_q[index]  <= tag;
      end
   end

   // Write-back addresses the evicted line by its stored tag, not the request tag.
   assign MEM_ADDRESS    = (state_q == WRITEBACK) ? {tag_q[index], index} : {tag, index};
   assign MEM_WRITE_DATA = line;
   assign MEM_READ       = mem_read_q;
   assign MEM_WRITE      = mem_write_q;
   assign BUSYWAIT       = RESET && ((state_q != IDLE) || ((READ || WRITE) && !hit));
   assign READ_DATA      = (state_q == IDLE && READ && !WRITE && hit) ? load_data : '0;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: cold miss, hits of every width, stores,
// dirty eviction, and reset abandoning transfers and discarding dirty lines.
module tb_data_cache;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         read, write;
   logic [31:0]  address, write_data;
   logic [2:0]   func3;
   logic [31:0]  read_data;
   logic         busywait, mem_read, mem_write;
   logic [27:0]  mem_address;
   logic [127:0] mem_write_data, mem_read_data;
   logic         mem_busywait;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   data_cache #(.LINES(8), .BLOCK_BYTES(16)) dut (
      .CLK            (clk),
      .RESET          (rst_n),
      .READ           (read),
      .WRITE          (write),
      .ADDRESS        (address),
      .WRITE_DATA     (write_data),
      .FUNC3          (func3),
      .READ_DATA      (read_data),
      .BUSYWAIT       (busywait),
      .MEM_READ       (mem_read),
      .MEM_WRITE      (mem_write),
      .MEM_ADDRESS    (mem_address),
      .MEM_WRITE_DATA (mem_write_data),
      .MEM_READ_DATA  (mem_read_data),
      .MEM_BUSYWAIT   (mem_busywait)
   );

   // Block memory: three busy cycles, then completes in the fourth.
   bit [127:0]  wr_mem [64];
   bit [63:0]   wr_valid;
   int unsigned lat_cnt;

   function automatic logic [127:0] init_block(input logic [5:0] a);
      case (a)
         6'd4:    return 128'h00000000_11223344_9ABCDEF0_12345678;
         6'd12:   return 128'h55555555_66666666_77777777_CAFEF00D;
         default: return {4{26'd0, a}};
      endcase
   endfunction

   assign mem_busywait  = (mem_read || mem_write) && (lat_cnt != 3);
   assign mem_read_data = wr_valid[mem_address[5:0]] ? wr_mem[mem_address[5:0]]
                                                      : init_block(mem_address[5:0]);

   always @(posedge clk) begin
      if ((mem_read || mem_write) && !mem_busywait) begin
         if (mem_write) begin
            wr_mem[mem_address[5:0]]   <= mem_write_data;
            wr_valid[mem_address[5:0]] <= 1'b1;
         end
         lat_cnt <= 0;
      end else if (mem_read || mem_write) begin
         lat_cnt <= lat_cnt + 1;
      end else begin
         lat_cnt <= 0;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic r, input logic w, input logic [31:0] a,
                      input logic [2:0] f3, input logic [31:0] wd);
      read       = r;
      write      = w;
      address    = a;
      func3      = f3;
      write_data = wd;
   endtask

   // Follows a miss to completion, checking handshake order and addresses.
   task automatic wait_miss(input string tag, input bit exp_wb, input logic [27:0] wb_addr,
                            input logic [127:0] wb_data, input logic [27:0] f_addr,
                            input int unsigned exp_busy);
      int unsigned  nbusy = 0;
      bit           done = 0, both = 0, saw_wb = 0, saw_f = 0, bad_order = 0;
      logic [27:0]  got_wb_addr = '0, got_f_addr = '0;
      logic [127:0] got_wb_data = '0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (mem_read && mem_write) both = 1;
         if (mem_write) begin
            saw_wb      = 1;
            got_wb_addr = mem_address;
            got_wb_data = mem_write_data;
            if (saw_f) bad_order = 1;
         end
         if (mem_read) begin
            saw_f      = 1;
            got_f_addr = mem_address;
         end
         if (busywait) nbusy++;
         else done = 1;
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_cycles"}, nbusy, exp_busy);
      chk({tag, "_both_req"}, both, 0);
      chk({tag, "_saw_wb"}, saw_wb, exp_wb);
      if (exp_wb) begin
         chk({tag, "_wb_addr"}, got_wb_addr, wb_addr);
         chk({tag, "_wb_data"}, got_wb_data, wb_data);
         chk({tag, "_wb_order"}, bad_order, 0);
      end
      chk({tag, "_saw_fetch"}, saw_f, 1);
      chk({tag, "_fetch_addr"}, got_f_addr, f_addr);
      chk({tag, "_mem_idle"}, {mem_read, mem_write}, 2'b00);
   endtask

   task automatic load_hit(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] exp);
      @(negedge clk);
      req(1'b1, 1'b0, a, f3, 32'h0);
      #1;
      chk({tag, "_data"}, read_data, exp);
      chk({tag, "_busy"}, busywait, 0);
   endtask

   task automatic store_hit(input string tag, input logic r, input logic [31:0] a,
                            input logic [2:0] f3, input logic [31:0] wd);
      @(negedge clk);
      req(r, 1'b1, a, f3, wd);
      #1;
      chk({tag, "_busy"}, busywait, 0);
      chk({tag, "_rdata"}, read_data, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      req(1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
      #1;
      chk("rst_busy", busywait, 0);
      chk("rst_memreq", {mem_read, mem_write}, 2'b00);
      chk("rst_rdata", read_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Cold load miss
      @(negedge clk);
      req(1'b1, 1'b0, 32'h0000_0040, 3'b010, 32'h0);
      #1;
      chk("cold_busy_now", busywait, 1);
      chk("cold_no_memreq_idle", mem_read, 0);
      wait_miss("cold", 1'b0, '0, '0, 28'h0000004, 5);
      chk("cold_data", read_data, 32'h1234_5678);

      // Immediate repeat is a zero-stall hit
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rehit_busy", busywait, 0);
         chk("rehit_memread", mem_read, 0);
         chk("rehit_data", read_data, 32'h1234_5678);
      end

      load_hit("lh_pos", 32'h0000_0042, 3'b001, 32'h0000_1234);
      load_hit("lh_neg", 32'h0000_0044, 3'b001, 32'hFFFF_DEF0);
      load_hit("lhu", 32'h0000_0045, 3'b101, 32'h0000_DEF0);
      load_hit("lw_unal", 32'h0000_0047, 3'b010, 32'h9ABC_DEF0);
      load_hit("lb_pos", 32'h0000_0043, 3'b000, 32'h0000_0012);
      load_hit("lbu", 32'h0000_0046, 3'b100, 32'h0000_00BC);

      // Stores on hit, then read them back
      store_hit("sb", 1'b0, 32'h0000_0041, 3'b000, 32'h5555_55AB);
      load_hit("lb_ab", 32'h0000_0041, 3'b000, 32'hFFFF_FFAB);
      load_hit("lbu_ab", 32'h0000_0041, 3'b100, 32'h0000_00AB);
      load_hit("lw_merge", 32'h0000_0040, 3'b010, 32'h1234_AB78);
      store_hit("rw_prio", 1'b1, 32'h0000_0048, 3'b001, 32'h7777_BEEF);
      load_hit("lhu_sh", 32'h0000_0048, 3'b101, 32'h0000_BEEF);
      load_hit("lh_sh", 32'h0000_004A, 3'b001, 32'h0000_1122);

      // Conflict miss on a dirty line
      @(negedge clk);
      req(1'b1, 1'b0, 32'h0000_00C0, 3'b010, 32'h0);
      #1;
      chk("evict_busy_now", busywait, 1);
      wait_miss("evict", 1'b1, 28'h0000004, 128'h00000000_1122BEEF_9ABCDEF0_1234AB78,
                28'h000000C, 9);
      chk("evict_data", read_data, 32'hCAFE_F00D);
      load_hit("evict_lb", 32'h0000_00C3, 3'b000, 32'hFFFF_FFCA);

      // Reset during FETCH abandons the transfer
      @(negedge clk);
      req(1'b1, 1'b0, 32'h0000_0040, 3'b010, 32'h0);
      @(negedge clk);
      chk("pre_rst_memread", mem_read, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_memread", mem_read, 0);
      chk("mid_rst_busy", busywait, 0);
      chk("mid_rst_rdata", read_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_miss", busywait, 1);
      wait_miss("post_rst", 1'b0, '0, '0, 28'h0000004, 5);
      chk("post_rst_data", read_data, 32'h1234_AB78);

      // Dirty data is dropped by reset: no write-back afterwards
      store_hit("sb_dirty", 1'b0, 32'h0000_0040, 3'b000, 32'h0000_0099);
      @(negedge clk);
      req(1'b0, 1'b0, 32'h0000_0040, 3'b010, 32'h0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      req(1'b1, 1'b0, 32'h0000_00C0, 3'b010, 32'h0);
      wait_miss("drop_dirty", 1'b0, '0, '0, 28'h000000C, 5);
      chk("drop_dirty_data", read_data, 32'hCAFE_F00D);
      @(negedge clk);
      req(1'b1, 1'b0, 32'h0000_0040, 3'b010, 32'h0);
      wait_miss("refetch", 1'b0, '0, '0, 28'h0000004, 5);
      chk("refetch_data", read_data, 32'h1234_AB78);

      @(negedge clk);
      req(1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
